// File: rtl/stat_reporter_pkg.sv
// rtl/stat_reporter_pkg.sv - shared types and frame layout constants for stat_reporter
package stat_reporter_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SNAP = 3'd1,
        HDR  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4
    } state_t;

    localparam int NUM_WORDS        = 5;
    localparam int BYTES_PER_WORD   = 4;
    localparam int FRAME_DATA_BYTES = NUM_WORDS * BYTES_PER_WORD;
    localparam int SNAP_W           = NUM_WORDS * BYTES_PER_WORD * 8;

    // Word slots inside the snapshot; slot 0 is transmitted first.
    localparam int WORD_DATA_CTR  = 0;
    localparam int WORD_ERROR_CTR = 1;
    localparam int WORD_DUT_DELAY = 2;
    localparam int WORD_MAXACC    = 3;
    localparam int WORD_MINACC    = 4;

    localparam logic [4:0] LAST_BYTE_IDX = 5'(FRAME_DATA_BYTES - 1);

endpackage

// File: rtl/stat_reporter_if.sv
// rtl/stat_reporter_if.sv - byte stream link from stat_reporter to the host/UART side
interface stat_reporter_if;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;

    modport master (
        output o_tx_data,
        output o_tx_valid,
        input  i_tx_ready
    );

    modport slave (
        input  o_tx_data,
        input  o_tx_valid,
        output i_tx_ready
    );
endinterface

// File: rtl/stat_byte_mux.sv
// rtl/stat_byte_mux.sv - picks payload byte 0..19 out of the 160-bit snapshot
module stat_byte_mux
    import stat_reporter_pkg::*;
(
    input  logic [SNAP_W-1:0] snapshot,
    input  logic [4:0]        byte_idx,
    output logic [7:0]        byte_out
);

    // Byte k sits at bits [8k+7:8k]; indices past the payload read as zero.
    always_comb begin
        byte_out = 8'h00;
        if (byte_idx < 5'(FRAME_DATA_BYTES)) begin
            byte_out = snapshot[{byte_idx, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/stat_reporter.sv
// rtl/stat_reporter.sv - snapshots five result counters and streams them as a 22-byte frame; STAT_REPORTER_PERIODIC_EN adds an auto-trigger timer
module stat_reporter
    import stat_reporter_pkg::*;
#(
    parameter logic [7:0] HEADER = 8'hA5
`ifdef STAT_REPORTER_PERIODIC_EN
    ,
    parameter int unsigned PERIOD = 1000000
`endif
) (
    input  logic            clk_dut,
    input  logic            reset,
    input  logic            i_trigger,
    input  logic [31:0]     i_data_ctr,
    input  logic [31:0]     i_error_ctr,
    input  logic [31:0]     i_dut_delay,
    input  logic [31:0]     i_maxacc,
    input  logic [31:0]     i_minacc,
    stat_reporter_if.master tx,
    output logic            o_busy,
    output logic            o_overrun,
    output logic [15:0]     o_frame_ctr
);

    state_t              state;
    logic                pending;
    logic [7:0]          checksum;
    logic [4:0]          byte_idx;
    logic [SNAP_W-1:0]   snapshot;
    logic [4:0]          mux_idx;
    logic [7:0]          mux_byte;
    logic                trig;
    logic                xfer;

    assign xfer   = tx.o_tx_valid & tx.i_tx_ready;
    assign o_busy = (state != IDLE);

`ifdef STAT_REPORTER_PERIODIC_EN
    localparam logic [31:0] PERIOD_LAST = 32'(PERIOD - 1);

    logic [31:0] interval_ctr;
    logic        auto_trig;

    // Free-running interval timer; wraps on the last count of each period.
    always_ff @(posedge clk_dut or negedge reset) begin
        if (!reset) begin
            interval_ctr <= 32'd0;
        end else if (interval_ctr == PERIOD_LAST) begin
            interval_ctr <= 32'd0;
        end else begin
            interval_ctr <= interval_ctr + 32'd1;
        end
    end

    assign auto_trig = (interval_ctr == PERIOD_LAST);
    assign trig      = i_trigger | auto_trig;
`else
    assign trig = i_trigger;
`endif

    // The byte loaded on a transfer is the one after the byte now on the link.
    assign mux_idx = (state == DATA) ? 5'(byte_idx + 5'd1) : 5'd0;

    stat_byte_mux u_byte_mux (
        .snapshot (snapshot),
        .byte_idx (mux_idx),
        .byte_out (mux_byte)
    );

    // Frame sequencer: snapshot, header, payload, checksum, plus trigger bookkeeping.
    always_ff @(posedge clk_dut or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pending       <= 1'b0;
            checksum      <= 8'h00;
            byte_idx      <= 5'd0;
            snapshot      <= '0;
            tx.o_tx_valid <= 1'b0;
            tx.o_tx_data  <= 8'h00;
            o_overrun     <= 1'b0;
            o_frame_ctr   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig || pending) begin
                        state   <= SNAP;
                        pending <= 1'b0;
                    end
                end
                SNAP: begin
                    snapshot[WORD_DATA_CTR*32  +: 32] <= i_data_ctr;
                    snapshot[WORD_ERROR_CTR*32 +: 32] <= i_error_ctr;
                    snapshot[WORD_DUT_DELAY*32 +: 32] <= i_dut_delay;
                    snapshot[WORD_MAXACC*32    +: 32] <= i_maxacc;
                    snapshot[WORD_MINACC*32    +: 32] <= i_minacc;
                    tx.o_tx_valid <= 1'b1;
                    tx.o_tx_data  <= HEADER;
                    state         <= HDR;
                end
                HDR: begin
                    if (xfer) begin
                        checksum     <= HEADER;
                        byte_idx     <= 5'd0;
                        tx.o_tx_data <= mux_byte;
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        checksum <= checksum ^ tx.o_tx_data;
                        if (byte_idx == LAST_BYTE_IDX) begin
                            tx.o_tx_data <= checksum ^ tx.o_tx_data;
                            state        <= CSUM;
                        end else begin
                            byte_idx     <= 5'(byte_idx + 5'd1);
                            tx.o_tx_data <= mux_byte;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        tx.o_tx_valid <= 1'b0;
                        tx.o_tx_data  <= 8'h00;
                        o_frame_ctr   <= o_frame_ctr + 16'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A trigger while a frame is in flight queues one frame; a second one is lost.
            if (trig && (state != IDLE)) begin
                if (!pending) begin
                    pending <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/stat_reporter.md
Name: stat_reporter

Overview:
Downstream consumer of the arithmetic testbench's result counters (data count, error count, DUT delay, max/min accuracy).
- On a trigger, snapshots all five 32-bit values atomically in one cycle.
- Serialises the snapshot as a framed byte stream over a valid/ready interface, feeding a UART/host link.
- Provides consistent, non-tearing readout while the scoreboard keeps counting.

Parameters:
HEADER, 8'hA5, frame start byte
PERIOD, 1000000, auto-trigger interval in clk_dut cycles (used only with the optional feature; must be >= 32)

Ports:
clk_dut  in  1  single clock
reset  in  1  asynchronous, active-low reset
i_trigger  in  1  one-cycle pulse requesting a report frame
i_data_ctr  in  32  data counter
i_error_ctr  in  32  error counter
i_dut_delay  in  32  measured DUT latency
i_maxacc  in  32  max accuracy value
i_minacc  in  32  min accuracy value
o_tx_data  out  8  byte to link
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  link accepts byte
o_busy  out  1  frame in progress (SNAP through CSUM)
o_overrun  out  1  sticky: trigger dropped
o_frame_ctr  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset (reset low, asynchronous): state IDLE; o_tx_valid=0, o_tx_data=0, o_busy=0, o_overrun=0, o_frame_ctr=0, pending=0, checksum=0. A reset mid-frame aborts the frame immediately; no partial recovery.
- FSM states:
  - IDLE: on i_trigger or pending -> SNAP; clear pending.
  - SNAP: one cycle; latch all five inputs into a 160-bit snapshot register -> HDR.
  - HDR: drive HEADER with o_tx_valid=1.
  - DATA: 20 bytes, word order data_ctr, error_ctr, dut_delay, maxacc, minacc; each word LSB byte first; 5-bit byte index 0..19.
  - CSUM: drive the XOR of HEADER and all 20 data bytes. On transfer -> IDLE and increment o_frame_ctr.
- Latency: trigger seen in cycle N (IDLE) -> SNAP in N+1 -> o_tx_valid=1 with HEADER from cycle N+2.
- Frame length is always 22 bytes.
- Handshake:
  - A transfer occurs on a clock edge where o_tx_valid && i_tx_ready.
  - While o_tx_valid=1 and no transfer, o_tx_data is held stable.
  - o_tx_valid never drops without a transfer, except on reset.
  - A ready-always sink gives 1 byte per cycle: the frame completes 24 cycles after the trigger.
- Checksum is a running register: loaded with HEADER on the HDR transfer, then XORed with each data byte on its transfer.
- Trigger while busy:
  - If pending=0, set pending=1. The pending frame starts at the IDLE cycle after CSUM.
  - If pending=1, set o_overrun=1 (sticky until reset).
  - A trigger in the same cycle the CSUM transfer completes counts as busy: it sets pending.
- Snapshot inputs are sampled only in SNAP; input changes during transmit do not affect the frame.
- o_busy=1 in SNAP, HDR, DATA, CSUM.

Optional Feature:
Macro STAT_REPORTER_PERIODIC_EN.
- Defined:
  - A 32-bit interval counter counts clk_dut cycles from reset.
  - On reaching PERIOD-1 it wraps to 0 and generates an internal trigger, ORed with i_trigger and subject to the same pending/overrun rules.
  - A simultaneous external and internal trigger counts as one trigger.
- Undefined: no counter; only i_trigger starts frames; PERIOD is unused.

Decomposition:
- Package stat_reporter_pkg:
  - FSM state enum (IDLE, SNAP, HDR, DATA, CSUM)
  - NUM_WORDS=5, BYTES_PER_WORD=4, FRAME_DATA_BYTES=20
  - Word order constants
- One sub-module, stat_byte_mux: selects byte index 0..19 from the 160-bit snapshot (combinational). It is kept separate so the bench can check ordering in isolation.

Test Plan:
- Basic frame, i_tx_ready=1:
  - Stimulus: i_data_ctr=0x01020304, other inputs 0, one trigger pulse.
  - Response: bytes A5,04,03,02,01, then 16x00, then checksum A1. o_busy high 23 cycles; o_frame_ctr=1.
- Backpressure:
  - Stimulus: same inputs; i_tx_ready toggles 1,0,0,1 repeating.
  - Response: identical byte sequence; o_tx_data stable whenever valid && !ready.
- Snapshot isolation:
  - Stimulus: i_error_ctr changes 0x5 -> 0x6 during DATA.
  - Response: bytes 5..8 = 05,00,00,00.
- Pending and overrun:
  - Stimulus: 3 triggers during one frame.
  - Response: exactly 2 frames back to back (1 IDLE cycle between); o_overrun=1; o_frame_ctr=2.
- Reset mid-frame:
  - Stimulus: reset low at byte 10.
  - Response: o_tx_valid=0 immediately (async); all outputs 0. After release and a new trigger, a full 22-byte frame starts with A5.
- STAT_REPORTER_PERIODIC_EN with PERIOD=64, ready=1, no i_trigger:
  - Response: frames start every 64 cycles; o_frame_ctr=4 after 4 periods plus 24 cycles; o_overrun=0.
